// File: rtl/sa_fifo_ctrl_pkg.sv
// sa_fifo_ctrl_pkg: sizes and pointer helper shared by the 61x64 FIFO controller
package sa_fifo_ctrl_pkg;
   localparam int DEPTH    = 61;
   localparam int AW       = 6;
   localparam int DW       = 64;
   localparam int OB_DEPTH = 3;
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);
   localparam logic [1:0]    OB_LAST  = 2'(OB_DEPTH - 1);
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction
endpackage

// File: rtl/sa_fifo_ctrl_obuf.sv
// sa_fifo_ctrl_obuf: 3-entry output buffer catching RAM read data in flight
module sa_fifo_ctrl_obuf
   import sa_fifo_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic [DW-1:0] o_dout,
   output logic [1:0]    o_cnt
);
   logic [DW-1:0] r_mem [OB_DEPTH];
   logic [1:0]    r_wp, r_rp, r_cnt;
   // data storage: tail written on push, contents need no reset
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_din;
   end
   // head/tail pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= (r_wp == OB_LAST) ? 2'd0 : r_wp + 2'd1;
         if (i_pop) r_rp <= (r_rp == OB_LAST) ? 2'd0 : r_rp + 2'd1;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      end
   end
   assign o_dout = r_mem[r_rp];
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/sa_fifo_ctrl_61x64.sv
// sa_fifo_ctrl_61x64: 61x64 FIFO controller for a 2-cycle-latency two-port RAM; SA_FIFO_CTRL_STATUS_EN adds count/almost_full
module sa_fifo_ctrl_61x64
   import sa_fifo_ctrl_pkg::*;
`ifdef SA_FIFO_CTRL_STATUS_EN
#(
   parameter int AFULL_THRESH = 56
)
`endif
(
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] ram_wa,
   output logic          ram_we,
   output logic [DW-1:0] ram_di,
   output logic [AW-1:0] ram_ra,
   output logic          ram_re,
   output logic          ram_ore,
   input  logic [DW-1:0] ram_dout,
   output logic [31:0]   ram_pd
`ifdef SA_FIFO_CTRL_STATUS_EN
   ,
   output logic [AW-1:0] count,
   output logic          almost_full
`endif
);
   logic [AW-1:0] r_wp, r_rp, r_ram_cnt;
   logic          r_s1, r_s2;
   logic [1:0]    w_ob_cnt;
   logic [2:0]    w_infl;
   logic [AW-1:0] w_occ;
   logic          w_we, w_re, w_pop;
   // words issued to the RAM but not yet popped; never allowed above the buffer size
   assign w_infl = {2'b0, r_s1} + {2'b0, r_s2} + {1'b0, w_ob_cnt};
   // total occupancy caps at DEPTH so the RAM plus buffer never hold more than 61 words
   assign w_occ  = r_ram_cnt + AW'(w_infl);
   assign wr_ready = ~reset & (w_occ != FULL_CNT);
   assign w_we     = wr_valid & wr_ready;
   assign rd_valid = ~reset & (w_ob_cnt != 2'd0);
   assign w_pop    = rd_valid & rd_ready;
   // issue only from registered ram_cnt so a word is never read in the cycle it is written
   assign w_re     = ~reset & (r_ram_cnt != '0) & (w_infl < 3'd3 + {2'b0, w_pop});
   assign ram_we   = w_we;
   assign ram_wa   = r_wp;
   assign ram_di   = wr_data;
   assign ram_re   = w_re;
   assign ram_ra   = r_rp;
   assign ram_ore  = ~reset & r_s1;
   assign ram_pd   = '0;
`ifdef SA_FIFO_CTRL_STATUS_EN
   assign count       = w_occ;
   assign almost_full = (w_occ >= AW'(AFULL_THRESH));
`endif
   // pointers, RAM occupancy and the two-stage read pipeline tracking RAM latency
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_ram_cnt <= '0;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
      end else begin
         if (w_we) r_wp <= ptr_inc(r_wp);
         if (w_re) r_rp <= ptr_inc(r_rp);
         r_ram_cnt <= r_ram_cnt + {{(AW-1){1'b0}}, w_we} - {{(AW-1){1'b0}}, w_re};
         r_s1      <= w_re;
         r_s2      <= r_s1;
      end
   end
   sa_fifo_ctrl_obuf u_obuf (
      .clk    (clk),
      .reset  (reset),
      .i_push (r_s2),
      .i_din  (ram_dout),
      .i_pop  (w_pop),
      .o_dout (rd_data),
      .o_cnt  (w_ob_cnt)
   );
endmodule

// File: tb/tb_sa_fifo_ctrl_61x64.sv
// tb_sa_fifo_ctrl_61x64: directed self-checking bench with a behavioural 2-cycle RAM
module tb_sa_fifo_ctrl_61x64;
   logic        clk = 1'b0, reset = 1'b1, wr_valid = 1'b0, rd_ready = 1'b0;
   logic [63:0] wr_data = '0;
   logic        wr_ready, rd_valid, ram_we, ram_re, ram_ore;
   logic [63:0] rd_data, ram_di, ram_dout;
   logic [5:0]  ram_wa, ram_ra, ra_q;
   logic [31:0] ram_pd;
   logic [63:0] mem [61];
   int n_err = 0, n_chk = 0;
   int wi, ri, acc, gaps, extra, started, saw60, wrapped;
`ifdef SA_FIFO_CTRL_STATUS_EN
   logic [5:0] count;
   logic       almost_full;
`endif
   localparam int N_RAND = 10000;

   always #5 clk = ~clk;

   // RAM model: address registered on ram_re, output register loaded on ram_ore
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ra_q <= ram_ra;
      if (ram_ore) ram_dout <= mem[ra_q];
   end

   sa_fifo_ctrl_61x64 dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .ram_wa   (ram_wa),
      .ram_we   (ram_we),
      .ram_di   (ram_di),
      .ram_ra   (ram_ra),
      .ram_re   (ram_re),
      .ram_ore  (ram_ore),
      .ram_dout (ram_dout),
      .ram_pd   (ram_pd)
`ifdef SA_FIFO_CTRL_STATUS_EN
      ,
      .count       (count),
      .almost_full (almost_full)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drain(input int n, input logic [63:0] base, input string tag);
      int got = 0;
      rd_ready = 1'b1;
      #1;
      for (int c = 0; c < 300; c++) begin
         if (rd_valid) begin
            chk(tag, rd_data, base + 64'(got));
            got++;
         end
         tick;
         if (got == n) break;
      end
      rd_ready = 1'b0;
      chk({tag, "_count"}, 64'(got), 64'(n));
   endtask

   initial begin
      tick;
      tick;
      wr_valid = 1'b1;
      #1;
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_ram_we", 64'(ram_we), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_ram_re", 64'(ram_re), 64'd0);
      chk("rst_ram_ore", 64'(ram_ore), 64'd0);
      chk("rst_ram_pd", 64'(ram_pd), 64'd0);
      wr_valid = 1'b0;
      reset = 1'b0;
      tick;
      chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);

      wr_valid = 1'b1;
      wr_data = 64'hA5A5_0000_0000_0001;
      rd_ready = 1'b1;
      #1;
      chk("lat_T_we", 64'(ram_we), 64'd1);
      chk("lat_T_wa", 64'(ram_wa), 64'd0);
      chk("lat_T_di", ram_di, 64'hA5A5_0000_0000_0001);
      tick;
      wr_valid = 1'b0;
      #1;
      chk("lat_T1_re", 64'(ram_re), 64'd1);
      chk("lat_T1_ra", 64'(ram_ra), 64'd0);
      chk("lat_T1_ore", 64'(ram_ore), 64'd0);
      tick;
      chk("lat_T2_ore", 64'(ram_ore), 64'd1);
      chk("lat_T2_re", 64'(ram_re), 64'd0);
      tick;
      chk("lat_T3_rd_valid", 64'(rd_valid), 64'd0);
      tick;
      chk("lat_T4_rd_valid", 64'(rd_valid), 64'd1);
      chk("lat_T4_rd_data", rd_data, 64'hA5A5_0000_0000_0001);
      tick;
      chk("lat_T5_empty", 64'(rd_valid), 64'd0);
      chk("lat_T5_no_re", 64'(ram_re), 64'd0);

      rd_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 61; i++) begin
         tick;
         wr_valid = 1'b1;
         wr_data = 64'h100 + 64'(i);
         #1;
         if (wr_ready) acc++;
      end
      chk("fill_accepts", 64'(acc), 64'd61);
      tick;
      wr_data = 64'hBAD;
      #1;
      chk("full_wr_ready", 64'(wr_ready), 64'd0);
      chk("full_ram_we", 64'(ram_we), 64'd0);
      chk("full_wp_held", 64'(ram_wa), 64'd1);
      chk("full_rd_valid", 64'(rd_valid), 64'd1);
      chk("full_head", rd_data, 64'h100);
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      #1;
      chk("full_pop_cycle_ready", 64'(wr_ready), 64'd0);
      tick;
      rd_ready = 1'b0;
      #1;
      chk("after_pop_ready", 64'(wr_ready), 64'd1);
      drain(60, 64'h101, "full_drain");

      wi = 0; ri = 0; gaps = 0; started = 0; saw60 = 0; wrapped = 0;
      rd_ready = 1'b1;
      for (int c = 0; c < 400 && ri < 200; c++) begin
         tick;
         wr_valid = (wi < 200);
         wr_data = 64'h1000 + 64'(wi);
         #1;
         if (wr_valid && wr_ready) begin
            if (ram_wa == 6'd60) saw60 = 1;
            else if (saw60 == 1 && ram_wa == 6'd0) wrapped = 1;
            wi++;
         end
         if (rd_valid) begin
            chk("stream_data", rd_data, 64'h1000 + 64'(ri));
            ri++;
            started = 1;
         end else if (started == 1) gaps++;
      end
      chk("stream_count", 64'(ri), 64'd200);
      chk("stream_gaps", 64'(gaps), 64'd0);
      chk("stream_wrap", 64'(wrapped), 64'd1);
      tick;
      wr_valid = 1'b0;
      rd_ready = 1'b0;

      for (int i = 0; i < 22; i++) begin
         tick;
         wr_valid = 1'b1;
         wr_data = 64'h2000 + 64'(i);
      end
      tick;
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
      chk("midrst_ram_re", 64'(ram_re), 64'd0);
      chk("midrst_wr_ready", 64'(wr_ready), 64'd0);
      tick;
      chk("midrst_next_rd_valid", 64'(rd_valid), 64'd0);
      chk("midrst_next_ore", 64'(ram_ore), 64'd0);
      reset = 1'b0;
      wr_valid = 1'b1;
      wr_data = 64'hDEAD_BEEF_0000_0022;
      #1;
      chk("midrst_wr_ready", 64'(wr_ready), 64'd1);
      tick;
      wr_valid = 1'b0;
      drain(1, 64'hDEAD_BEEF_0000_0022, "midrst_first");
      rd_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         tick;
         if (rd_valid) extra++;
      end
      chk("midrst_no_stale", 64'(extra), 64'd0);

      wi = 0; ri = 0;
      for (int c = 0; c < 60000 && ri < N_RAND; c++) begin
         tick;
         wr_valid = (wi < N_RAND) && ($urandom_range(0, 9) < 7);
         wr_data = 64'hC0DE_0000_0000_0000 | 64'(wi);
         rd_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (wr_valid && wr_ready) wi++;
         if (rd_valid && rd_ready) begin
            chk("rand_data", rd_data, 64'hC0DE_0000_0000_0000 | 64'(ri));
            ri++;
         end
      end
      chk("rand_count", 64'(ri), 64'(N_RAND));
      tick;
      wr_valid = 1'b0;
      rd_ready = 1'b0;

`ifdef SA_FIFO_CTRL_STATUS_EN
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      for (int i = 0; i < 55; i++) begin
         tick;
         wr_valid = 1'b1;
         wr_data = 64'h3000 + 64'(i);
      end
      tick;
      wr_valid = 1'b0;
      #1;
      chk("af_55_count", 64'(count), 64'd55);
      chk("af_55_flag", 64'(almost_full), 64'd0);
      wr_valid = 1'b1;
      tick;
      wr_valid = 1'b0;
      #1;
      chk("af_56_count", 64'(count), 64'd56);
      chk("af_56_flag", 64'(almost_full), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
